// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - shared VALU opcodes, sequencer state encoding and lane defaults
package valu_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 8;

  localparam logic [2:0] VALU_OP_ADD = 3'b000;
  localparam logic [2:0] VALU_OP_MUL = 3'b001;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == VALU_OP_ADD) || (op == VALU_OP_MUL);
  endfunction

endpackage

// File: rtl/valu.sv
// rtl/valu.sv - 8-bit vector ALU lane: ADD and MUL, results truncated to lane width
//
// Ports:
//   in1, in2 : lane operands
//   VALUOp   : operation code (ADD / MUL); undefined codes yield zero
//   out      : lane result, carry / upper product bits discarded
module valu
  import valu_pkg::*;
#(
  parameter int W = DEF_LANE_W
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   VALUOp,
  output logic [W-1:0] out
);

  always_comb begin
    out = '0;
    case (VALUOp)
      VALU_OP_ADD: out = in1 + in2;
      VALU_OP_MUL: out = in1 * in2;
      default:     out = '0;
    endcase
  end

endmodule

// File: rtl/valu_lane_sequencer.sv
// rtl/valu_lane_sequencer.sv - steps a packed vector through one VALU, one byte lane per cycle
//
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   start          : request, sampled only in IDLE
//   op             : VALU op code (ADD / MUL legal)
//   va, vb         : packed vector operands, lane i at [LANE_W*i +: LANE_W]
//   lane_mask      : bit i set processes lane i, clear passes va lane i through
//   busy           : high in RUN and DONE
//   done           : one-cycle completion pulse, result valid in that cycle
//   err            : with done, flags an illegal op
//   result         : assembled vector result, held until the next legal run
module valu_lane_sequencer
  import valu_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [2:0]              op,
  input  logic [LANES*LANE_W-1:0] va,
  input  logic [LANES*LANE_W-1:0] vb,
  input  logic [LANES-1:0]        lane_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [LANES*LANE_W-1:0] result
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  seq_state_e              state, state_n;
  logic [CNT_W-1:0]        cnt;
  logic [LANES*LANE_W-1:0] a_q, b_q;
  logic [2:0]              op_q;
  logic [LANES-1:0]        mask_q;
  logic                    err_flag;
  logic [LANES-1:0]        lane_we;

  logic [LANE_W-1:0]       valu_in1, valu_in2, valu_out;
  logic [2:0]              valu_op;

  // Next state and status outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (start) state_n = is_legal_op(op) ? SEQ_RUN : SEQ_DONE;
      end
      SEQ_RUN: begin
        busy = 1'b1;
        if (cnt == LAST_LANE) state_n = SEQ_DONE;
      end
      SEQ_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        err     = err_flag;
        state_n = SEQ_IDLE;
      end
      default: state_n = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= SEQ_IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= VALU_OP_ADD;
      mask_q   <= '0;
      err_flag <= 1'b0;
    end else begin
      state <= state_n;
      if (state == SEQ_IDLE && start) begin
        if (is_legal_op(op)) begin
          a_q      <= va;
          b_q      <= vb;
          op_q     <= op;
          mask_q   <= lane_mask;
          cnt      <= '0;
          err_flag <= 1'b0;
        end else begin
          // Illegal op: operands stay as they were, only the error is recorded
          err_flag <= 1'b1;
        end
      end else if (state == SEQ_RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The VALU only ever sees the latched op while lanes are being stepped;
  // otherwise it idles on a zero ADD.
  always_comb begin
    valu_in1 = '0;
    valu_in2 = '0;
    valu_op  = VALU_OP_ADD;
    if (state == SEQ_RUN) begin
      valu_in1 = a_q[cnt*LANE_W +: LANE_W];
      valu_in2 = b_q[cnt*LANE_W +: LANE_W];
      valu_op  = op_q;
    end
  end

  valu #(.W(LANE_W)) u_valu (
    .in1    (valu_in1),
    .in2    (valu_in2),
    .VALUOp (valu_op),
    .out    (valu_out)
  );

  assign lane_we = (state == SEQ_RUN) ? (LANES'(1) << cnt) : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      result <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i])
          result[i*LANE_W +: LANE_W] <= mask_q[i] ? valu_out : a_q[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_valu_lane_sequencer.sv
// tb/tb_valu_lane_sequencer.sv - self-checking bench for valu_lane_sequencer
module tb_valu_lane_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] va, vb;
  logic [3:0]  lane_mask;
  logic        busy, done, err;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_res;
  logic [31:0] exp1, exp2;

  valu_lane_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .va        (va),
    .vb        (vb),
    .lane_mask (lane_mask),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: per-lane arithmetic on plain integers; illegal ops leave prev untouched
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] m,
                                        input logic [31:0] prev);
    logic [31:0] r;
    int la, lb, lr;
    if (o != 3'd0 && o != 3'd1) return prev;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      la = int'((a >> (8*i)) & 32'hFF);
      lb = int'((b >> (8*i)) & 32'hFF);
      if (!m[i])          lr = la;
      else if (o == 3'd0) lr = (la + lb) % 256;
      else                lr = (la * lb) % 256;
      r = r | (32'(lr) << (8*i));
    end
    return r;
  endfunction

  // Issues one request in the current cycle (N) and checks cycles N+1 .. end
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] m);
    logic legal;
    legal = (o == 3'd0) || (o == 3'd1);
    model_res = model(o, a, b, m, model_res);
    op = o; va = a; vb = b; lane_mask = m; start = 1'b1;
    step();
    start = 1'b0;
    // scramble inputs after the start cycle; they must have no effect
    va = $urandom; vb = $urandom; op = 3'($urandom); lane_mask = 4'($urandom);
    if (legal) begin
      for (int k = 1; k <= 5; k++) begin
        check($sformatf("busy_c%0d", k), 32'(busy), 32'd1);
        check($sformatf("done_c%0d", k), 32'(done), 32'(k == 5));
        check($sformatf("err_c%0d", k), 32'(err), 32'd0);
        if (k == 5) check("result", result, model_res);
        step();
      end
    end else begin
      check("ill_busy", 32'(busy), 32'd1);
      check("ill_done", 32'(done), 32'd1);
      check("ill_err", 32'(err), 32'd1);
      check("ill_result", result, model_res);
      step();
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'd0; va = '0; vb = '0; lane_mask = '0;
    model_res = '0;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", result, 32'd0);
    reset_n = 1'b1;
    step();

    // Directed cases
    run_op(3'b000, 32'h01020304, 32'h10203040, 4'b1111);
    check("add_basic", result, 32'h11223344);
    run_op(3'b000, 32'hFF100302, 32'h01100405, 4'b1111);
    check("add_wrap", result, 32'h00200707);
    run_op(3'b001, 32'hFF100302, 32'h01100405, 4'b1111);
    check("mul_trunc", result, 32'hFF000C0A);
    run_op(3'b011, 32'h12345678, 32'h9ABCDEF0, 4'b1111);
    check("illegal_keep", result, 32'hFF000C0A);
    run_op(3'b000, 32'hAABBCCDD, 32'h01010101, 4'b0101);
    check("mask_0101", result, 32'hAABCCCDE);
    run_op(3'b001, 32'h5A5A5A5A, 32'h03030303, 4'b0000);
    check("mask_0000", result, 32'h5A5A5A5A);

    // start held high: accepted at cycles 0, 6 and 12 only
    op = 3'b000; va = 32'h01020304; vb = 32'h10203040; lane_mask = 4'b1111; start = 1'b1;
    exp1 = model(3'b000, 32'h01020304, 32'h10203040, 4'b1111, 32'h0);
    exp2 = model(3'b000, 32'h0A0B0C0D, 32'h10203040, 4'b1111, 32'h0);
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 2) va = 32'h0A0B0C0D;
      if (c == 13) start = 1'b0;
      check($sformatf("hold_busy_c%0d", c), 32'(busy), 32'(c % 6 != 0));
      check($sformatf("hold_done_c%0d", c), 32'(done), 32'(c % 6 == 5));
      if (c == 5) check("hold_res1", result, exp1);
      if (c == 11 || c == 17) check($sformatf("hold_res_c%0d", c), result, exp2);
    end
    model_res = exp2;

    // Reset in cycle 3 of a run
    run_op(3'b001, 32'h02030405, 32'h02020202, 4'b1111); // leaves a nonzero result
    op = 3'b000; va = 32'h11111111; vb = 32'h22222222; lane_mask = 4'b1111; start = 1'b1;
    step();                 // cycle 1
    start = 1'b0;
    step(); step();         // cycle 3
    reset_n = 1'b0;
    step();                 // cycle 4
    reset_n = 1'b1;
    model_res = '0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    step();                 // cycle 5
    check("abort_done2", 32'(done), 32'd0);
    run_op(3'b000, 32'h01010101, 32'h02020202, 4'b1111);
    check("post_abort", result, 32'h03030303);

    // Randomized operations against the reference
    for (int n = 0; n < 40; n++) begin
      logic [2:0] ro;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      ro = 3'b000;
      else if (sel < 8) ro = 3'b001;
      else              ro = 3'($urandom_range(2, 7));
      run_op(ro, $urandom, $urandom, 4'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/valu_lane_sequencer.md
# valu_lane_sequencer

Multicycle controller that applies the 8-bit VALU across a 32-bit packed vector, one byte lane per cycle. It sits between the processor control FSM and a single internal VALU instance. It latches two vector operands, an operation code and a lane mask on a start request, then steps lanes 0..3 through the VALU. It assembles the 32-bit result and signals completion with a one-cycle done pulse.

## Interface
- LANES, 4, number of byte lanes per vector; fixed at 4 for this release.
- LANE_W, 8, lane width in bits; must match the VALU datapath width.
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  reset; **one clock; reset is synchronous and active-low**.
- start  input  1  request; sampled only in IDLE.
- op  input  3  VALUOp code: 3'b000 = ADD, 3'b001 = MUL; all other codes are illegal.
- va  input  32  vector A; lane i = va[8i+7:8i].
- vb  input  32  vector B, same lane layout.
- lane_mask  input  4  bit i = 1 means process lane i; 0 means pass va lane i through unchanged.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- err  output  1  high together with done when op was illegal.
- result  output  32  assembled vector result.

## Operation
- States: IDLE, RUN, DONE. Encoding is 2 bits: IDLE = 0, RUN = 1, DONE = 2; code 3 is unreachable and recovers to IDLE.
- IDLE, start = 1, legal op:
  - Latch va, vb, op and lane_mask into internal registers.
  - Set lane counter to 0 and go to RUN.
- IDLE, start = 1, illegal op:
  - Latch nothing and leave result unchanged.
  - Go directly to DONE with err pending.
- RUN: the VALU is driven with latched lane[cnt] of A and B and the latched op.
  - At the clock edge, result lane[cnt] is written with VALU out if mask[cnt] = 1, otherwise with A lane[cnt].
  - cnt increments. After cnt = 3, go to DONE.
- DONE: done = 1 and err = (illegal-op flag). Return to IDLE next cycle.
- start is ignored in RUN and DONE; there is no queueing, and the requester must re-assert.
- Arithmetic:
  - ADD: 8-bit sum, carry discarded (0xFF + 0x01 = 0x00).
  - MUL: low 8 bits of the product (0x10 × 0x10 = 0x00).
  - No cross-lane carry.
- The VALU inputs are driven with the latched op only in RUN. In IDLE and DONE the VALU op is forced to ADD with zero inputs, so the VALU never sees an op it does not define.
- result holds its value from the last completed operation until lanes are overwritten by the next legal run.

## Timing
- Reset (reset_n = 0 at a rising edge): state IDLE, cnt 0, busy 0, done 0, err 0, result 0x00000000, all latched operands 0.
- Reset asserted mid-RUN aborts immediately at that edge. There is no done pulse, and any partial result is cleared to 0.
- Legal op, start sampled in cycle N:
  - RUN covers cycles N+1..N+4 (lanes 0..3).
  - DONE is cycle N+5, with done = 1 and the full result valid.
  - IDLE is cycle N+6, and the earliest next start is accepted there.
  - Latency is 5 cycles; throughput is one operation per 6 cycles.
- Illegal op, start in cycle N: DONE with err = 1 in cycle N+1, IDLE in N+2.
- Latency is fixed regardless of lane_mask; a mask of 0000 still takes 4 RUN cycles.
- busy rises in cycle N+1 and falls at the start of the IDLE cycle.
- Input changes to va, vb, op and lane_mask after the start cycle have no effect.

## Structure
- Shared package valu_pkg:
  - VALU_OP_ADD = 3'b000 and VALU_OP_MUL = 3'b001.
  - State encoding constants SEQ_IDLE, SEQ_RUN, SEQ_DONE.
  - LANES and LANE_W defaults.
- The sequencer contains one sub-module: the existing VALU, instantiated as u_valu. The sequencer drives its in1, in2 and VALUOp ports and reads its out port.
- Lane select is a combinational mux on cnt. Result write-back is a per-lane enable decoded from cnt and the RUN state.

## Test plan
- ADD, va = 0x01020304, vb = 0x10203040, mask = 1111, start in cycle 0 -> busy in cycles 1-5, done only in cycle 5, result = 0x11223344, err = 0.
- ADD wrap plus MUL, va = 0xFF100302, vb = 0x01100405: ADD gives 0x00200707 (0xFF lane wraps to 0x00); MUL gives 0xFF000C0A (0x10 × 0x10 truncates to 0x00).
- Mask, ADD, va = 0xAABBCCDD, vb = 0x01010101, mask = 0101 -> result = 0xAABCCCDE, done still in cycle 5.
- Illegal op = 3'b011 with start in cycle 0 -> done = 1 and err = 1 in cycle 1, result unchanged from the previous value, IDLE in cycle 2.
- start held high continuously with legal ops -> accepted in cycles 0, 6 and 12 only. Changing va in cycle 2 does not affect the first result.
- reset_n = 0 in cycle 3 of a run -> at that edge busy = 0, result = 0, and no done pulse follows. A new start in cycle 5 completes normally, with done in cycle 10.
